// File: rtl/iob_merge_arb.sv
// Merges N_MASTERS request/response ports onto one slave port, fixed-priority or round-robin.
// Zero added latency; no buffering, so a master holds its request until its routed ready returns.
module iob_merge_arb #(
   parameter  int N_MASTERS = 2,
   parameter  int DATA_W    = 32,
   parameter  int ADDR_W    = 32,
   parameter  int ARB_MODE  = 1,
   localparam int REQ_W     = 1 + ADDR_W + DATA_W + DATA_W/8,
   localparam int RESP_W    = DATA_W + 1,
   localparam int IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_MASTERS*REQ_W-1:0]  m_req,
   output logic [N_MASTERS*RESP_W-1:0] m_resp,
   output logic [REQ_W-1:0]            s_req,
   input  logic [RESP_W-1:0]           s_resp,
   output logic [N_MASTERS-1:0]        m_grant,
   output logic                        busy
);

   typedef struct packed {
      logic                  valid;
      logic [ADDR_W-1:0]     addr;
      logic [DATA_W-1:0]     wdata;
      logic [DATA_W/8-1:0]   wstrb;
   } req_t;

   typedef struct packed {
      logic [DATA_W-1:0]     rdata;
      logic                  ready;
   } resp_t;

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_MASTERS - 1);

   state_t               state;
   logic [IDX_W-1:0]     gnt;
   logic [IDX_W-1:0]     last;

   req_t                 req_arr [N_MASTERS];
   logic [N_MASTERS-1:0] req_vld;
   resp_t                resp_in;
   logic                 s_ready;
   logic                 any_vld;
   logic [IDX_W-1:0]     win;
   logic [IDX_W-1:0]     cand;
   logic                 found;
   logic [IDX_W-1:0]     cur;
   logic                 act;

   always_comb begin
      for (int k = 0; k < N_MASTERS; k++) begin
         req_arr[k] = req_t'(m_req[k*REQ_W +: REQ_W]);
         req_vld[k] = req_arr[k].valid;
      end
   end

   assign resp_in = resp_t'(s_resp);
   assign s_ready = resp_in.ready;
   assign any_vld = |req_vld;

   // Fixed mode scans upward so the highest valid index is the last to overwrite win.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      if (ARB_MODE == 0) begin
         for (int k = 0; k < N_MASTERS; k++) begin
            if (req_vld[k]) begin
               win = IDX_W'(k);
            end
         end
      end else begin
         for (int i = 1; i <= N_MASTERS; i++) begin
            cand = IDX_W'((int'(last) + i) % N_MASTERS);
            if (!found && req_vld[cand]) begin
               win   = cand;
               found = 1'b1;
            end
         end
      end
   end

   // While BUSY the grant is locked to gnt, even if that master has dropped valid.
   assign cur = (state == BUSY) ? gnt : win;
   assign act = !rst && ((state == BUSY) || any_vld);

   always_comb begin
      s_req   = '0;
      m_resp  = '0;
      m_grant = '0;
      if (act) begin
         s_req                            = req_arr[cur];
         m_resp[int'(cur)*RESP_W +: RESP_W] = s_resp;
         m_grant[cur]                     = 1'b1;
      end
   end

   assign busy = (state == BUSY) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         last  <= LAST_RST;
      end else begin
         case (state)
            IDLE: begin
               if (any_vld) begin
                  if (s_ready) begin
                     last <= win;
                  end else begin
                     state <= BUSY;
                     gnt   <= win;
                  end
               end
            end
            BUSY: begin
               if (s_ready) begin
                  state <= IDLE;
                  last  <= gnt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/iob_merge_arb.md
IOB_MERGE_ARB -- requirements
Module: iob_merge_arb

Interface
REQ-001 The block SHALL have parameter N_MASTERS, default 2, meaning the number of master ports (1..16).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width (multiple of 8).
REQ-003 The block SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-004 The block SHALL have parameter ARB_MODE, default 1, meaning 0 = fixed priority with the highest index winning, 1 = round-robin.
REQ-005 The block SHALL define REQ_W = 1+ADDR_W+DATA_W+DATA_W/8 with fields ordered MSB to LSB as {valid, addr, wdata, wstrb}, and RESP_W = DATA_W+1 with fields {rdata, ready}, ready at the LSB.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port m_req, input, N_MASTERS*REQ_W bits: master k's request at bits [(k+1)*REQ_W-1 : k*REQ_W].
REQ-009 The block SHALL have port m_resp, output, N_MASTERS*RESP_W bits: master k's response, same slicing as m_req.
REQ-010 The block SHALL have port s_req, output, REQ_W bits: the request to the slave.
REQ-011 The block SHALL have port s_resp, input, RESP_W bits: the response from the slave.
REQ-012 The block SHALL have port m_grant, output, N_MASTERS bits: one-hot indication of the master that currently owns the slave.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in state BUSY.

Function
REQ-014 Each master SHALL hold valid and its request fields stable from assertion until the cycle its m_resp ready is 1; each transaction completes in the cycle s_resp.ready=1.
REQ-015 The block SHALL implement an FSM with states IDLE and BUSY, a granted index gnt (width max(1,clog2(N_MASTERS))) and a round-robin pointer last.
REQ-016 In IDLE with no master valid, s_req SHALL be all zero, every m_resp SHALL be zero and m_grant SHALL be zero.
REQ-017 In IDLE with at least one valid master, the block SHALL choose a winner combinationally and forward that master's m_req to s_req in the same cycle (zero added latency).
REQ-018 In fixed mode, the winner SHALL be the highest-index valid master.
REQ-019 In round-robin mode, the winner SHALL be the first valid master found when searching indices last+1, last+2, ..., wrapping modulo N_MASTERS.
REQ-020 If s_resp.ready=1 in the winning cycle, the transaction SHALL complete, the FSM SHALL stay in IDLE, and last SHALL be set to the winner index.
REQ-021 If s_resp.ready=0 in the winning cycle, the FSM SHALL go to BUSY and register gnt = winner.
REQ-022 In BUSY, s_req SHALL equal m_req of master gnt; other masters' requests SHALL be ignored, and the grant SHALL never change before completion.
REQ-023 In BUSY, when s_resp.ready=1, the FSM SHALL return to IDLE and last SHALL be set to gnt; arbitration SHALL resume on the next cycle.
REQ-024 m_resp of the granted master (winner in IDLE, gnt in BUSY) SHALL equal s_resp combinationally; all other m_resp slices SHALL be zero.
REQ-025 If the granted master drops valid in BUSY (a protocol violation), the block SHALL keep the grant and keep forwarding its request fields until s_resp.ready.
REQ-026 m_grant SHALL be one-hot of the winner in IDLE when any master is valid, and one-hot of gnt in BUSY.
REQ-027 With N_MASTERS=1, the block SHALL reduce to a pass-through with FSM tracking; index width 1, pointer fixed at 0.
REQ-028 s_resp.ready arriving while no transaction is granted SHALL be ignored and SHALL not update last.

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL set state=IDLE, gnt=0 and last=N_MASTERS-1, so master 0 has first round-robin priority.
REQ-030 While rst=1, s_req, m_resp and m_grant SHALL be all zero and busy SHALL be 0, regardless of inputs.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction with no response routed; after release, arbitration SHALL restart from the reset pointer.

Verification (N_MASTERS=3, DATA_W=32, ADDR_W=32)
REQ-032 Single master: m1 valid, addr=0x100, slave ready after 3 cycles, rdata=0xCAFE0001 -> s_req carries addr 0x100 from cycle 0, busy for 3 cycles, only m1 receives ready with rdata=0xCAFE0001.
REQ-033 Round-robin: m0, m1 and m2 hold valid continuously, ready 1 cycle after each grant -> grant order 0,1,2,0,1,2.
REQ-034 Fixed mode (ARB_MODE=0): m0 and m2 valid simultaneously -> m2 granted first, then m0; if m2 re-requests, it wins again.
REQ-035 Lock: m0 granted, m2 asserts valid during BUSY -> s_req stays on m0 until ready; m2 sees m_resp=0 throughout.
REQ-036 Zero-wait: s_resp.ready tied to 1, m1 valid -> completes in the same cycle, busy never 1, last=1.
REQ-037 Reset mid-BUSY: rst pulsed while m2 is granted -> outputs zero during reset; afterwards m0 and m2 both valid -> m0 granted first.
